// File: rtl/hps_ext_mailbox.sv
// HPS extension mailbox: outgoing FIFO drained by complete GET transactions,
// incoming SET messages length-checked and released as a one-cycle pulse.
module hps_ext_mailbox #(
    parameter logic [15:0] CMD_GET = 16'h0034,
    parameter logic [15:0] CMD_SET = 16'h0035,
    parameter int unsigned WORDS   = 3,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    inout  wire  [35:0]               EXT_BUS,
    input  logic                      tx_valid,
    input  logic [16*WORDS-1:0]       tx_data,
    output logic                      tx_ready,
    output logic [$clog2(DEPTH):0]    tx_level,
    output logic                      rx_valid,
    output logic [16*WORDS-1:0]       rx_data,
    output logic                      rx_drop
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned WIDX      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [9:0]  LAST_WORD = 10'(WORDS);

    logic [15:0] io_din;
    logic        io_strobe;
    logic        io_enable;
    logic        unused_ext;

    logic [15:0] io_dout_q;
    logic        dout_en_q;
    logic        enable_q;
    logic        armed_q;
    logic [9:0]  byte_cnt_q;
    logic [15:0] cmd_q;
    logic        had_msg_q;
    logic [7:0]  seq_q;
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;

    logic [WORDS-1:0][15:0] mem [DEPTH];
    logic [WORDS-1:0][15:0] head;
    logic [WORDS-1:0][15:0] shadow_q;
    logic [WORDS-1:0][15:0] rx_data_q;
    logic                   rx_valid_q;
    logic                   rx_drop_q;

    logic [AW:0]     occ;
    logic [7:0]      occ_byte;
    logic            empty;
    logic            full;
    logic            push;
    logic            txn_end;
    logic            strobe_act;
    logic            in_payload;
    logic            len_ok;
    logic            get_done;
    logic            set_done;
    logic [WIDX-1:0] word_idx;

    assign io_din           = EXT_BUS[31:16];
    assign io_strobe        = EXT_BUS[33];
    assign io_enable        = EXT_BUS[34];
    assign unused_ext       = EXT_BUS[35];
    assign EXT_BUS[15:0]    = io_dout_q;
    assign EXT_BUS[32]      = dout_en_q;

    assign occ      = wr_ptr_q - rd_ptr_q;
    assign occ_byte = 8'(occ);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push     = tx_valid && !full;
    assign head     = mem[rd_ptr_q[AW-1:0]];

    assign tx_ready = !full;
    assign tx_level = occ;
    assign rx_valid = rx_valid_q;
    assign rx_drop  = rx_drop_q;
    assign rx_data  = rx_data_q;

    // A transaction only counts once io_enable has been seen low since reset,
    // and only if its command strobe actually arrived.
    assign txn_end    = enable_q && !io_enable && armed_q && (byte_cnt_q != 10'd0);
    assign strobe_act = io_enable && io_strobe && armed_q;
    assign in_payload = (byte_cnt_q != 10'd0) && (byte_cnt_q <= LAST_WORD);
    assign len_ok     = (byte_cnt_q > LAST_WORD);
    assign word_idx   = WIDX'(byte_cnt_q - 10'd1);
    assign get_done   = txn_end && (cmd_q == CMD_GET) && had_msg_q && len_ok;
    assign set_done   = txn_end && (cmd_q == CMD_SET);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            io_dout_q  <= '0;
            dout_en_q  <= 1'b0;
            enable_q   <= 1'b0;
            armed_q    <= 1'b0;
            byte_cnt_q <= '0;
            cmd_q      <= '0;
            had_msg_q  <= 1'b0;
            seq_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            shadow_q   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_drop_q  <= 1'b0;
        end else begin
            enable_q <= io_enable;
            if (!io_enable) begin
                armed_q <= 1'b1;
            end

            if (!io_enable) begin
                io_dout_q  <= '0;
                dout_en_q  <= 1'b0;
                byte_cnt_q <= '0;
            end else if (strobe_act) begin
                if (byte_cnt_q != 10'h3FF) begin
                    byte_cnt_q <= byte_cnt_q + 10'd1;
                end
                io_dout_q <= '0;
                if (byte_cnt_q == 10'd0) begin
                    cmd_q     <= io_din;
                    dout_en_q <= (io_din == CMD_GET) || (io_din == CMD_SET);
                    had_msg_q <= !empty;
                    if (io_din == CMD_GET) begin
                        io_dout_q <= {seq_q, occ_byte};
                    end
                end else if (in_payload) begin
                    if ((cmd_q == CMD_GET) && !empty) begin
                        io_dout_q <= head[word_idx];
                    end
                    if (cmd_q == CMD_SET) begin
                        shadow_q[word_idx] <= io_din;
                    end
                end
            end

            rx_valid_q <= set_done && len_ok;
            rx_drop_q  <= set_done && !len_ok;
            if (set_done && len_ok) begin
                rx_data_q <= shadow_q;
            end

            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            // Only a complete GET advances the head; a push never touches it.
            if (get_done) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                seq_q    <= seq_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= tx_data;
        end
    end

endmodule

// File: tb/tb_hps_ext_mailbox.sv
// Scoreboard bench for hps_ext_mailbox: stimulus queues expected bus words and
// rx pulses, monitors pop and compare whenever the DUT presents them.
module tb_hps_ext_mailbox;

    localparam logic [15:0] CMD_GET = 16'h0034;
    localparam logic [15:0] CMD_SET = 16'h0035;

    typedef struct {
        logic [15:0] dout;
        logic        en;
    } dout_exp_t;

    typedef struct {
        logic        drop;
        logic [47:0] data;
    } rx_exp_t;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] din     = '0;
    logic        strobe  = 1'b0;
    logic        enable  = 1'b0;
    logic        tx_valid = 1'b0;
    logic [47:0] tx_data  = '0;
    logic        tx_ready;
    logic [2:0]  tx_level;
    logic        rx_valid;
    logic [47:0] rx_data;
    logic        rx_drop;
    wire  [35:0] ext_bus;
    logic [15:0] io_dout;
    logic        dout_en;

    int n_vec  = 0;
    int n_fail = 0;

    dout_exp_t exp_dout[$];
    rx_exp_t   exp_rx[$];
    logic      pend = 1'b0;

    assign ext_bus[31:16] = din;
    assign ext_bus[33]    = strobe;
    assign ext_bus[34]    = enable;
    assign ext_bus[35]    = 1'b0;
    assign io_dout        = ext_bus[15:0];
    assign dout_en        = ext_bus[32];

    hps_ext_mailbox #(
        .CMD_GET (CMD_GET),
        .CMD_SET (CMD_SET),
        .WORDS   (3),
        .DEPTH   (4)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .EXT_BUS  (ext_bus),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx_level (tx_level),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_drop  (rx_drop)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Bus word monitor: the word for a strobe sampled at a posedge is checked
    // at the following negedge.
    always @(posedge clk_sys) pend <= strobe && enable;

    always @(negedge clk_sys) begin : mon_dout
        dout_exp_t e;
        if (pend) begin
            if (exp_dout.size() == 0) begin
                check("dout_unexpected", 64'(io_dout), 64'hDEAD);
            end else begin
                e = exp_dout.pop_front();
                check("io_dout", 64'(io_dout), 64'(e.dout));
                check("dout_en", 64'(dout_en), 64'(e.en));
            end
        end
    end

    always @(negedge clk_sys) begin : mon_rx
        rx_exp_t e;
        if (reset_n && (rx_valid || rx_drop)) begin
            if (exp_rx.size() == 0) begin
                check("rx_unexpected", {62'd0, rx_valid, rx_drop}, 64'd0);
            end else begin
                e = exp_rx.pop_front();
                check("rx_kind", {62'd0, rx_valid, rx_drop}, e.drop ? 64'd1 : 64'd2);
                if (!e.drop) check("rx_data", 64'(rx_data), 64'(e.data));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        check("rst_io_dout", 64'(io_dout), 64'd0);
        check("rst_dout_en", 64'(dout_en), 64'd0);
        check("rst_tx_level", 64'(tx_level), 64'd0);
        check("rst_tx_ready", 64'(tx_ready), 64'd1);
        @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    task automatic push_msg(input logic [47:0] d);
        @(negedge clk_sys);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk_sys);
        tx_valid = 1'b0;
    endtask

    task automatic strobe_word(input logic [15:0] d, input logic [15:0] exp, input logic en);
        dout_exp_t e;
        @(negedge clk_sys);
        din    = d;
        strobe = 1'b1;
        e.dout = exp;
        e.en   = en;
        exp_dout.push_back(e);
        @(negedge clk_sys);
        strobe = 1'b0;
    endtask

    task automatic begin_txn();
        @(negedge clk_sys);
        enable = 1'b1;
    endtask

    task automatic end_txn();
        @(negedge clk_sys);
        enable = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic get_words(input logic [15:0] w0, input logic [47:0] d, input int n,
                             input int extra);
        strobe_word(CMD_GET, w0, 1'b1);
        for (int k = 0; k < n; k++) strobe_word(16'h0000, d[16*k +: 16], 1'b1);
        for (int k = 0; k < extra; k++) strobe_word(16'h0000, 16'h0000, 1'b1);
    endtask

    task automatic set_words(input logic [15:0] cmd, input logic [47:0] d, input int n,
                             input logic en);
        strobe_word(cmd, 16'h0000, en);
        for (int k = 0; k < n; k++) strobe_word(d[16*k +: 16], 16'h0000, en);
    endtask

    task automatic expect_rx(input logic drop, input logic [47:0] d);
        rx_exp_t e;
        e.drop = drop;
        e.data = d;
        exp_rx.push_back(e);
    endtask

    localparam logic [47:0] MA = 48'h3333_2222_1111;
    localparam logic [47:0] MB = 48'h6666_5555_4444;
    localparam logic [47:0] MC = 48'h9999_8888_7777;
    localparam logic [47:0] MD = 48'hCCCC_BBBB_AAAA;
    localparam logic [47:0] ME = 48'hFFFF_EEEE_DDDD;

    initial begin
        repeat (2) @(negedge clk_sys);
        check("rst_rx_valid", 64'(rx_valid), 64'd0);
        check("rst_rx_drop", 64'(rx_drop), 64'd0);
        check("rst_rx_data", 64'(rx_data), 64'd0);
        reset_n = 1'b1;

        // Full GET pops, seq advances, extra strobe reads 0
        push_msg(MA);
        check("lvl_after_push", 64'(tx_level), 64'd1);
        begin_txn();
        get_words(16'h0001, MA, 3, 1);
        end_txn();
        check("lvl_after_get", 64'(tx_level), 64'd0);
        begin_txn();
        get_words(16'h0100, 48'd0, 1, 0);
        end_txn();
        check("lvl_empty_get", 64'(tx_level), 64'd0);

        // Truncated GET leaves head in place
        do_reset();
        push_msg(MA);
        begin_txn();
        get_words(16'h0001, MA, 1, 0);
        end_txn();
        check("lvl_trunc", 64'(tx_level), 64'd1);
        begin_txn();
        get_words(16'h0001, MA, 3, 0);
        end_txn();
        check("lvl_reread", 64'(tx_level), 64'd0);

        // Full FIFO, held-off push, refused push in the pop cycle
        do_reset();
        push_msg(MA);
        push_msg(MB);
        push_msg(MC);
        push_msg(MD);
        check("full_ready", 64'(tx_ready), 64'd0);
        check("full_lvl", 64'(tx_level), 64'd4);
        @(negedge clk_sys);
        tx_valid = 1'b1;
        tx_data  = ME;
        repeat (2) @(negedge clk_sys);
        tx_valid = 1'b0;
        check("holdoff_lvl", 64'(tx_level), 64'd4);
        begin_txn();
        get_words(16'h0004, MA, 3, 0);
        @(negedge clk_sys);
        enable   = 1'b0;
        tx_valid = 1'b1;
        tx_data  = ME;
        @(negedge clk_sys);
        tx_valid = 1'b0;
        check("popcyc_lvl", 64'(tx_level), 64'd3);
        check("popcyc_ready", 64'(tx_ready), 64'd1);
        begin_txn();
        get_words(16'h0103, MB, 3, 0);
        end_txn();
        check("lvl_two", 64'(tx_level), 64'd2);

        // Reset in the middle of a GET with three queued
        push_msg(ME);
        begin_txn();
        get_words(16'h0203, MC, 1, 0);
        do_reset();
        strobe_word(CMD_GET, 16'h0000, 1'b0);
        end_txn();
        check("post_rst_lvl", 64'(tx_level), 64'd0);
        begin_txn();
        get_words(16'h0000, 48'd0, 1, 0);
        end_txn();

        // Complete SET
        begin_txn();
        set_words(CMD_SET, MD, 3, 1'b1);
        expect_rx(1'b0, MD);
        @(negedge clk_sys);
        enable = 1'b0;
        @(negedge clk_sys);
        check("set_pulse_timing", 64'(rx_valid), 64'd1);
        @(negedge clk_sys);
        check("set_pulse_len", 64'(rx_valid), 64'd0);
        check("set_rx_data", 64'(rx_data), 64'(MD));

        // Short SET drops, unknown command does nothing
        begin_txn();
        set_words(CMD_SET, 48'h0000_5678_1234, 2, 1'b1);
        expect_rx(1'b1, 48'd0);
        end_txn();
        @(negedge clk_sys);
        check("drop_keeps_data", 64'(rx_data), 64'(MD));
        begin_txn();
        set_words(16'h0099, 48'h0003_0002_0001, 3, 1'b0);
        end_txn();
        repeat (2) @(negedge clk_sys);
        check("unk_rx_data", 64'(rx_data), 64'(MD));
        check("unk_lvl", 64'(tx_level), 64'd0);

        repeat (3) @(negedge clk_sys);
        check("dout_queue_drained", 64'(exp_dout.size()), 64'd0);
        check("rx_queue_drained", 64'(exp_rx.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/hps_ext_mailbox.md
Name: hps_ext_mailbox

Overview:
- Parametrised successor to the single-slot HPS extension command endpoint.
- Sits on the 36-bit EXT_BUS between the HPS I/O controller and core logic.
- Outgoing core-to-HPS messages go into a FIFO and are delivered reliably: a message is popped only after a complete GET transaction. They are never overwritten by a toggle.
- Incoming HPS-to-core SET messages of WORDS 16-bit words are validated for length before release as a one-cycle pulse.

Parameters:
- CMD_GET, 16'h0034, command code for the HPS reading the head of the outgoing queue.
- CMD_SET, 16'h0035, command code for the HPS writing one incoming message.
- WORDS, 3, payload length in 16-bit words, range 1..64.
- DEPTH, 4, outgoing FIFO depth in messages, power of two, range 2..64.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- EXT_BUS  inout  36  [15:0] io_dout (out), [31:16] io_din (in), [32] dout_en (out), [33] io_strobe (in), [34] io_enable (in), [35] unused.
- tx_valid  in  1  core offers an outgoing message.
- tx_data  in  16*WORDS  outgoing payload; word k is bits [16k+15:16k].
- tx_ready  out  1  FIFO not full.
- tx_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- rx_valid  out  1  one-cycle pulse: rx_data holds a complete new message.
- rx_data  out  16*WORDS  last complete incoming message, held until the next one.
- rx_drop  out  1  one-cycle pulse: a SET ended with fewer than WORDS payload words.

Behaviour:
- Reset (async, reset_n=0): all of the following are cleared.
  - io_dout=0, dout_en=0, byte_cnt=0, cmd=0.
  - FIFO empty, tx_ready=1, tx_level=0, seq=0.
  - rx_valid=0, rx_data=0, rx_drop=0.
  - The SET shadow register and the short-transfer flag.
- Transaction framing:
  - While io_enable=0: io_dout=0, dout_en=0, byte_cnt=0.
  - Falling edge of io_enable (registered previous value 1, current value 0) ends a transaction.
- Strobes within io_enable=1:
  - byte_cnt increments on each io_strobe and saturates at 1023.
  - Strobe 0 latches cmd=io_din.
  - dout_en <= 1 if io_din is CMD_GET or CMD_SET, else 0.
  - io_dout is registered and valid the cycle after the strobe.
  - io_dout defaults to 0 on any strobe not listed below.
- GET:
  - Strobe 0: io_dout={seq[7:0], occupancy saturated to 8 bits}.
  - Strobe k, 1<=k<=WORDS: io_dout = head word k-1. If the FIFO is empty, io_dout=0.
  - Strobes beyond WORDS: io_dout=0.
- GET completion:
  - Pop the head if, at transaction end, cmd==CMD_GET, occupancy>0 at strobe 0, and byte_cnt>=WORDS+1.
  - On pop, seq increments and wraps at 255.
  - A truncated GET leaves the FIFO unchanged, so the HPS re-reads the same message.
- SET:
  - Strobe k, 1<=k<=WORDS: shadow word k-1 <= io_din.
  - Strobes beyond WORDS: ignored.
- SET completion, at transaction end with cmd==CMD_SET:
  - If byte_cnt>=WORDS+1: rx_data<=shadow and rx_valid pulses for exactly 1 cycle.
  - Otherwise rx_drop pulses for 1 cycle and rx_data is unchanged.
- Push and full/empty rules:
  - Push when tx_valid && tx_ready. There is no combinational path from tx_valid to tx_ready.
  - tx_valid while full is ignored; the producer must hold it.
  - tx_ready = (occupancy<DEPTH).
- Simultaneous push and pop:
  - Both occur in the same cycle and occupancy is unchanged.
  - When full, a push in the pop cycle is still refused, because tx_ready was 0 that cycle.
- Head stability: the head entry is not altered by a push during a GET. Only the pop at transaction end advances the read pointer.
- Pointers: log2(DEPTH)+1 bits with natural wrap; full/empty is derived from the MSB difference.
- Unknown commands: dout_en=0 and no state change at transaction end.
- Reset mid-transaction: the transaction is lost, with no pop and no rx pulse. After reset the first strobe is treated as strobe 0 only once io_enable has been low.

Test Plan:
- Push A=(16'h1111,16'h2222,16'h3333) -> tx_level=1. Full GET reads 16'h0001, 16'h1111, 16'h2222, 16'h3333. After io_enable falls: tx_level=0. Next GET word0 = 16'h0100.
- Push A, then GET with only 2 strobes -> no pop. Next full GET returns A again with word0=16'h0001.
- Push DEPTH=4 messages -> tx_ready=0. A 5th tx_valid is held off. Then a full GET plus a same-cycle push at the falling edge -> the push is refused; tx_level=3 and tx_ready=1 on the next cycle.
- SET of 16'h0035,16'hAAAA,16'hBBBB,16'hCCCC -> one rx_valid pulse 1 cycle after io_enable falls; rx_data=48'hCCCC_BBBB_AAAA.
- SET with 2 payload words -> rx_drop pulse; rx_valid=0; rx_data retains the prior value. Command 16'h0099 -> dout_en=0, io_dout=0, no pulses.
- Assert reset_n=0 mid-GET with 3 messages queued -> outputs cleared asynchronously; tx_level=0, tx_ready=1, seq=0.
